// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB line-state constants and default timing.
package usb_pkg;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam int USB_CLKS_PER_BIT = 8;
    localparam int USB_SAMPLE_PT    = 3;
    localparam int USB_STUFF_LEN    = 6;

endpackage

// File: rtl/usb_bit_timer.sv
// rtl/usb_bit_timer.sv - D+ edge detector and resyncing bit timer producing the sample strobe.
module usb_bit_timer
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = USB_CLKS_PER_BIT,
    parameter int SAMPLE_PT    = USB_SAMPLE_PT
) (
    input  logic clk,
    input  logic n_rst,
    input  logic rcving,
    input  logic d_plus,
    output logic sample
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic             dp_q;
    logic             line_edge;
    logic [CNT_W-1:0] cnt;

    assign line_edge = (d_plus != dp_q);
    assign sample    = rcving && (cnt == CNT_W'(SAMPLE_PT));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_q <= 1'b1;
            cnt  <= '0;
        end else begin
            dp_q <= d_plus;
            // Any D+ transition restarts the bit period so sampling tracks the sender.
            if (!rcving || line_edge) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/usb_rx_bit_decoder.sv
// rtl/usb_rx_bit_decoder.sv - USB FS receive NRZI decoder with bit unstuffing, EOP and stuff-error flags.
module usb_rx_bit_decoder
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = USB_CLKS_PER_BIT,
    parameter int SAMPLE_PT    = USB_SAMPLE_PT,
    parameter int STUFF_LEN    = USB_STUFF_LEN
) (
    input  logic clk,
    input  logic n_rst,
    input  logic rcving,
    input  logic d_plus,
    input  logic d_minus,
    output logic serial_out,
    output logic shift_en,
    output logic stuff_err,
    output logic eop
);

    localparam int ONES_W = $clog2(STUFF_LEN + 1);

    logic              sample;
    logic              last_dp;
    logic [ONES_W-1:0] ones;
    logic              line_se0;
    logic              nrzi_bit;
    logic              at_limit;

    usb_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .SAMPLE_PT   (SAMPLE_PT)
    ) u_bit_timer (
        .clk   (clk),
        .n_rst (n_rst),
        .rcving(rcving),
        .d_plus(d_plus),
        .sample(sample)
    );

    assign line_se0 = ({d_plus, d_minus} == LINE_SE0);
    assign nrzi_bit = (d_plus == last_dp);
    assign at_limit = (ones == ONES_W'(STUFF_LEN));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            serial_out <= 1'b0;
            shift_en   <= 1'b0;
            stuff_err  <= 1'b0;
            eop        <= 1'b0;
            ones       <= '0;
            last_dp    <= 1'b1;
        end else begin
            shift_en  <= 1'b0;
            stuff_err <= 1'b0;
            eop       <= 1'b0;
            if (!rcving) begin
                ones    <= '0;
                last_dp <= 1'b1;
            end else if (sample) begin
                if (line_se0) begin
                    // SE0 carries no NRZI level, so the reference level is left alone.
                    eop  <= 1'b1;
                    ones <= '0;
                end else begin
                    last_dp <= d_plus;
                    if (at_limit) begin
                        // A 0 here is the stuffed bit and is dropped; a 1 is a violation.
                        stuff_err <= nrzi_bit;
                        ones      <= '0;
                    end else begin
                        shift_en   <= 1'b1;
                        serial_out <= nrzi_bit;
                        ones       <= nrzi_bit ? ones + ONES_W'(1) : '0;
                    end
                end
            end
        end
    end

endmodule
